// File: rtl/instruction_decoder_seq.sv
`default_nettype none
// ============================================================================
// Module   : instruction_decoder_seq
// Brief    : Registered microsequencer instruction decoder with tracked stack
//            pointer, two-cycle POP and multi-cycle sequencer reset.
// Revision : 1.0 - initial release
// ============================================================================

module instruction_decoder_seq #(
    parameter logic [2:0] DECODER_ID  = 3'b010,
    parameter int         STACK_DEPTH = 8,
    parameter int         RST_CYCLES  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] id,
    input  logic [4:0] instr_in,
    input  logic       cc_in,
    input  logic       instr_en,
    output logic       cen,
    output logic       rst,
    output logic       oen,
    output logic       inc,
    output logic       rsel,
    output logic       rce,
    output logic       pc_mux_sel,
    output logic       push,
    output logic       pop,
    output logic       src_sel,
    output logic       stack_we,
    output logic       stack_re,
    output logic       out_ce,
    output logic [1:0] a_mux_sel,
    output logic [1:0] b_mux_sel,
    output logic [3:0] sp,
    output logic       stack_full,
    output logic       stack_empty,
    output logic       busy,
    output logic       err
);

    typedef struct packed {
        logic       cen;
        logic       rst;
        logic       oen;
        logic       inc;
        logic       rsel;
        logic       rce;
        logic       pc_mux_sel;
        logic       push;
        logic       pop;
        logic       src_sel;
        logic       stack_we;
        logic       stack_re;
        logic       out_ce;
        logic [1:0] a_mux_sel;
        logic [1:0] b_mux_sel;
        logic       busy;
        logic       err;
    } ctrl_t;

    localparam ctrl_t c_IDLE = ctrl_t'({13'b0, 2'b10, 2'b10, 2'b00});

    localparam logic [4:0] c_OP_FETCH_PC = 5'b01000;
    localparam logic [4:0] c_OP_FETCH_RD = 5'b01001;
    localparam logic [4:0] c_OP_LOAD_R   = 5'b01010;
    localparam logic [4:0] c_OP_PUSH_PC  = 5'b01011;
    localparam logic [4:0] c_OP_POP      = 5'b01100;
    localparam logic [4:0] c_OP_CJP      = 5'b01101;
    localparam logic [4:0] c_OP_RESET    = 5'b01110;

    localparam logic [1:0] c_ST_DECODE   = 2'd0;
    localparam logic [1:0] c_ST_POP2     = 2'd1;
    localparam logic [1:0] c_ST_RST_HOLD = 2'd2;

    localparam logic [3:0] c_SP_FULL = 4'(STACK_DEPTH);
    // A single-cycle reset needs no hold state at all.
    localparam logic [1:0] c_ST_AFTER_RST = (RST_CYCLES > 1) ? c_ST_RST_HOLD : c_ST_DECODE;
    localparam logic [3:0] c_RST_CNT_INIT = (RST_CYCLES > 1) ? 4'(RST_CYCLES - 2) : 4'd0;

    ctrl_t      r_ctrl;
    logic [1:0] r_state;
    logic [3:0] r_sp;
    logic [3:0] r_rst_cnt;

    ctrl_t      w_nxt;
    logic [1:0] w_state_nxt;
    logic [3:0] w_sp_nxt;
    logic [3:0] w_rst_cnt_nxt;
    logic       w_full;
    logic       w_empty;

    assign w_full  = (r_sp == c_SP_FULL);
    assign w_empty = (r_sp == 4'd0);

    always_comb begin
        w_nxt         = c_IDLE;
        w_state_nxt   = c_ST_DECODE;
        w_sp_nxt      = r_sp;
        w_rst_cnt_nxt = r_rst_cnt;

        // A deselected slot idles and abandons any sequence in flight.
        if (id == DECODER_ID) begin
            case (r_state)
                c_ST_POP2: begin
                    w_nxt.pop        = 1'b1;
                    w_nxt.src_sel    = 1'b1;
                    w_nxt.pc_mux_sel = 1'b1;
                    w_nxt.oen        = 1'b1;
                    w_nxt.busy       = 1'b1;
                    if (!w_empty) begin
                        w_sp_nxt = r_sp - 4'd1;
                    end
                end
                c_ST_RST_HOLD: begin
                    w_nxt.rst  = 1'b1;
                    w_nxt.busy = 1'b1;
                    w_sp_nxt   = 4'd0;
                    if (r_rst_cnt != 4'd0) begin
                        w_state_nxt   = c_ST_RST_HOLD;
                        w_rst_cnt_nxt = r_rst_cnt - 4'd1;
                    end
                end
                default: begin
                    // The edge that closes the last busy cycle still discards its inputs.
                    if (!r_ctrl.busy) begin
                        if (instr_en) begin
                            w_nxt.oen = 1'b1;
                        end else begin
                            case (instr_in)
                                c_OP_FETCH_PC: begin
                                    w_nxt.out_ce     = 1'b1;
                                    w_nxt.rsel       = 1'b1;
                                    w_nxt.rce        = 1'b1;
                                    w_nxt.oen        = 1'b1;
                                    w_nxt.pc_mux_sel = 1'b1;
                                    w_nxt.inc        = 1'b1;
                                    w_nxt.b_mux_sel  = 2'b00;
                                end
                                c_OP_FETCH_RD: begin
                                    w_nxt.out_ce     = 1'b1;
                                    w_nxt.rsel       = 1'b1;
                                    w_nxt.rce        = 1'b1;
                                    w_nxt.cen        = 1'b1;
                                    w_nxt.oen        = 1'b1;
                                    w_nxt.pc_mux_sel = 1'b1;
                                    w_nxt.inc        = 1'b1;
                                    w_nxt.a_mux_sel  = 2'b00;
                                    w_nxt.b_mux_sel  = 2'b11;
                                end
                                c_OP_LOAD_R: begin
                                    w_nxt.rce        = 1'b1;
                                    w_nxt.oen        = 1'b1;
                                    w_nxt.pc_mux_sel = 1'b1;
                                    w_nxt.inc        = 1'b1;
                                    w_nxt.b_mux_sel  = 2'b00;
                                end
                                c_OP_PUSH_PC: begin
                                    w_nxt.rce        = 1'b1;
                                    w_nxt.oen        = 1'b1;
                                    w_nxt.pc_mux_sel = 1'b1;
                                    w_nxt.inc        = 1'b1;
                                    w_nxt.b_mux_sel  = 2'b00;
                                    if (!w_full) begin
                                        w_nxt.push     = 1'b1;
                                        w_nxt.stack_we = 1'b1;
                                        w_sp_nxt       = r_sp + 4'd1;
                                    end else begin
                                        w_nxt.err = 1'b1;
                                    end
                                end
                                c_OP_POP: begin
                                    w_nxt.oen = 1'b1;
                                    if (w_empty) begin
                                        w_nxt.err = 1'b1;
                                    end else begin
                                        w_nxt.stack_re = 1'b1;
                                        w_nxt.busy     = 1'b1;
                                        w_state_nxt    = c_ST_POP2;
                                    end
                                end
                                c_OP_CJP: begin
                                    w_nxt.oen = 1'b1;
                                    if (cc_in) begin
                                        w_nxt.src_sel = 1'b1;
                                        w_nxt.out_ce  = 1'b1;
                                    end else begin
                                        w_nxt.pc_mux_sel = 1'b1;
                                        w_nxt.inc        = 1'b1;
                                    end
                                end
                                c_OP_RESET: begin
                                    w_nxt.rst     = 1'b1;
                                    w_nxt.busy    = 1'b1;
                                    w_sp_nxt      = 4'd0;
                                    w_state_nxt   = c_ST_AFTER_RST;
                                    w_rst_cnt_nxt = c_RST_CNT_INIT;
                                end
                                default: begin
                                    w_nxt = c_IDLE;
                                end
                            endcase
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ctrl    <= c_IDLE;
            r_state   <= c_ST_DECODE;
            r_sp      <= 4'd0;
            r_rst_cnt <= 4'd0;
        end else begin
            r_ctrl    <= w_nxt;
            r_state   <= w_state_nxt;
            r_sp      <= w_sp_nxt;
            r_rst_cnt <= w_rst_cnt_nxt;
        end
    end

    assign cen         = r_ctrl.cen;
    assign rst         = r_ctrl.rst;
    assign oen         = r_ctrl.oen;
    assign inc         = r_ctrl.inc;
    assign rsel        = r_ctrl.rsel;
    assign rce         = r_ctrl.rce;
    assign pc_mux_sel  = r_ctrl.pc_mux_sel;
    assign push        = r_ctrl.push;
    assign pop         = r_ctrl.pop;
    assign src_sel     = r_ctrl.src_sel;
    assign stack_we    = r_ctrl.stack_we;
    assign stack_re    = r_ctrl.stack_re;
    assign out_ce      = r_ctrl.out_ce;
    assign a_mux_sel   = r_ctrl.a_mux_sel;
    assign b_mux_sel   = r_ctrl.b_mux_sel;
    assign busy        = r_ctrl.busy;
    assign err         = r_ctrl.err;
    assign sp          = r_sp;
    assign stack_full  = w_full;
    assign stack_empty = w_empty;

endmodule

`default_nettype wire

// File: tb/tb_instruction_decoder_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_instruction_decoder_seq
// Brief    : Directed self-checking bench for instruction_decoder_seq.
// Revision : 1.0 - initial release
// ============================================================================

module tb_instruction_decoder_seq;

    localparam logic [4:0] c_NOP      = 5'b00000;
    localparam logic [4:0] c_FETCH_PC = 5'b01000;
    localparam logic [4:0] c_FETCH_RD = 5'b01001;
    localparam logic [4:0] c_LOAD_R   = 5'b01010;
    localparam logic [4:0] c_PUSH     = 5'b01011;
    localparam logic [4:0] c_POP      = 5'b01100;
    localparam logic [4:0] c_CJP      = 5'b01101;
    localparam logic [4:0] c_RESET    = 5'b01110;

    // Observed vector: {cen,rst,oen,inc,rsel,rce,pc_mux_sel,push,pop,src_sel,
    //                   stack_we,stack_re,out_ce,a_mux_sel,b_mux_sel,busy,err}
    localparam logic [18:0] V_CEN  = 19'h40000;
    localparam logic [18:0] V_RST  = 19'h20000;
    localparam logic [18:0] V_OEN  = 19'h10000;
    localparam logic [18:0] V_INC  = 19'h08000;
    localparam logic [18:0] V_RSEL = 19'h04000;
    localparam logic [18:0] V_RCE  = 19'h02000;
    localparam logic [18:0] V_PCM  = 19'h01000;
    localparam logic [18:0] V_PUSH = 19'h00800;
    localparam logic [18:0] V_POP  = 19'h00400;
    localparam logic [18:0] V_SRC  = 19'h00200;
    localparam logic [18:0] V_SWE  = 19'h00100;
    localparam logic [18:0] V_SRE  = 19'h00080;
    localparam logic [18:0] V_OCE  = 19'h00040;
    localparam logic [18:0] M_IDLE = 19'h00028;
    localparam logic [18:0] M_B00  = 19'h00020;
    localparam logic [18:0] M_RD   = 19'h0000C;
    localparam logic [18:0] V_BUSY = 19'h00002;
    localparam logic [18:0] V_ERR  = 19'h00001;

    localparam logic [18:0] E_IDLE      = M_IDLE;
    localparam logic [18:0] E_PUSH_OK   = V_RCE | V_OEN | V_PCM | V_INC | V_PUSH | V_SWE | M_B00;
    localparam logic [18:0] E_PUSH_FULL = V_RCE | V_OEN | V_PCM | V_INC | V_ERR | M_B00;
    localparam logic [18:0] E_POP1      = V_SRE | V_OEN | V_BUSY | M_IDLE;
    localparam logic [18:0] E_POP2      = V_POP | V_SRC | V_PCM | V_OEN | V_BUSY | M_IDLE;
    localparam logic [18:0] E_POP_EMPTY = V_OEN | V_ERR | M_IDLE;
    localparam logic [18:0] E_FETCH_PC  = V_OCE | V_RSEL | V_RCE | V_OEN | V_PCM | V_INC | M_B00;
    localparam logic [18:0] E_FETCH_RD  = V_OCE | V_RSEL | V_RCE | V_CEN | V_OEN | V_PCM | V_INC | M_RD;
    localparam logic [18:0] E_LOAD_R    = V_RCE | V_OEN | V_PCM | V_INC | M_B00;
    localparam logic [18:0] E_CJP_T     = V_SRC | V_OEN | V_OCE | M_IDLE;
    localparam logic [18:0] E_CJP_F     = V_OEN | V_PCM | V_INC | M_IDLE;
    localparam logic [18:0] E_RESET     = V_RST | V_BUSY | M_IDLE;
    localparam logic [18:0] E_DIS       = V_OEN | M_IDLE;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] id;
    logic [4:0] instr_in;
    logic       cc_in;
    logic       instr_en;
    logic       cen, rst, oen, inc, rsel, rce, pc_mux_sel, push, pop, src_sel;
    logic       stack_we, stack_re, out_ce;
    logic [1:0] a_mux_sel, b_mux_sel;
    logic [3:0] sp;
    logic       stack_full, stack_empty, busy, err;
    logic [18:0] obs;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    instruction_decoder_seq #(
        .DECODER_ID  (3'b010),
        .STACK_DEPTH (8),
        .RST_CYCLES  (2)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id          (id),
        .instr_in    (instr_in),
        .cc_in       (cc_in),
        .instr_en    (instr_en),
        .cen         (cen),
        .rst         (rst),
        .oen         (oen),
        .inc         (inc),
        .rsel        (rsel),
        .rce         (rce),
        .pc_mux_sel  (pc_mux_sel),
        .push        (push),
        .pop         (pop),
        .src_sel     (src_sel),
        .stack_we    (stack_we),
        .stack_re    (stack_re),
        .out_ce      (out_ce),
        .a_mux_sel   (a_mux_sel),
        .b_mux_sel   (b_mux_sel),
        .sp          (sp),
        .stack_full  (stack_full),
        .stack_empty (stack_empty),
        .busy        (busy),
        .err         (err)
    );

    assign obs = {cen, rst, oen, inc, rsel, rce, pc_mux_sel, push, pop, src_sel,
                  stack_we, stack_re, out_ce, a_mux_sel, b_mux_sel, busy, err};

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] op);
        instr_in = op;
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        id       = 3'b010;
        instr_in = c_NOP;
        cc_in    = 1'b0;
        instr_en = 1'b0;
        step();
        step();
        check_eq("reset_vec", obs, E_IDLE);
        check_eq("reset_sp", sp, 0);
        check_eq("reset_empty", stack_empty, 1);
        check_eq("reset_full", stack_full, 0);

        rst_n = 1'b1;
        step();
        check_eq("nop_vec", obs, E_IDLE);

        // Fill the stack, then one push too many
        for (int i = 1; i <= 8; i++) begin
            issue(c_PUSH);
            check_eq("push_vec", obs, E_PUSH_OK);
            check_eq("push_sp", sp, i);
            check_eq("push_full", stack_full, (i == 8) ? 1 : 0);
        end
        issue(c_PUSH);
        check_eq("push_full_vec", obs, E_PUSH_FULL);
        check_eq("push_full_sp", sp, 8);

        // POP directly after the suppressed push; FETCH_PC offered while busy
        issue(c_POP);
        check_eq("pop1_vec", obs, E_POP1);
        check_eq("pop1_sp", sp, 8);
        issue(c_FETCH_PC);
        check_eq("pop2_vec", obs, E_POP2);
        check_eq("pop2_sp", sp, 7);
        step();
        check_eq("busy_discard_vec", obs, E_IDLE);
        step();
        check_eq("fetch_pc_vec", obs, E_FETCH_PC);

        for (int k = 0; k < 2; k++) begin
            issue(c_POP);
            instr_in = c_NOP;
            step();
            step();
        end
        check_eq("pre_reset_sp", sp, 5);

        // Sequencer RESET from sp=5, PUSH held during busy is discarded
        issue(c_RESET);
        check_eq("reset1_vec", obs, E_RESET);
        check_eq("reset1_sp", sp, 0);
        issue(c_PUSH);
        check_eq("reset2_vec", obs, E_RESET);
        step();
        check_eq("reset_done_vec", obs, E_IDLE);
        check_eq("reset_done_sp", sp, 0);

        issue(c_POP);
        check_eq("pop_empty_vec", obs, E_POP_EMPTY);
        check_eq("pop_empty_sp", sp, 0);
        issue(c_NOP);
        check_eq("err_pulse_vec", obs, E_IDLE);

        // From sp=2: POP with FETCH_RD offered while busy, then POP at sp=1
        issue(c_PUSH);
        issue(c_PUSH);
        check_eq("sp_two", sp, 2);
        issue(c_POP);
        check_eq("pop_a1_vec", obs, E_POP1);
        issue(c_FETCH_RD);
        check_eq("pop_a2_vec", obs, E_POP2);
        check_eq("pop_a2_sp", sp, 1);
        step();
        check_eq("pop_a_discard", obs, E_IDLE);
        issue(c_POP);
        check_eq("pop_b1_vec", obs, E_POP1);
        check_eq("pop_b1_empty", stack_empty, 0);
        instr_in = c_NOP;
        step();
        check_eq("pop_b2_sp", sp, 0);
        check_eq("pop_b2_empty", stack_empty, 1);
        step();

        cc_in = 1'b1;
        issue(c_CJP);
        check_eq("cjp_taken_vec", obs, E_CJP_T);
        cc_in = 1'b0;
        issue(c_CJP);
        check_eq("cjp_cont_vec", obs, E_CJP_F);

        id = 3'b011;
        issue(c_FETCH_RD);
        check_eq("other_id_vec", obs, E_IDLE);
        id = 3'b010;
        issue(c_FETCH_RD);
        check_eq("fetch_rd_vec", obs, E_FETCH_RD);
        issue(c_LOAD_R);
        check_eq("load_r_vec", obs, E_LOAD_R);
        issue(5'b11111);
        check_eq("unknown_vec", obs, E_IDLE);

        // Deselect during POP2 aborts it without touching sp
        issue(c_PUSH);
        issue(c_PUSH);
        issue(c_POP);
        check_eq("abort_pop1_vec", obs, E_POP1);
        id = 3'b011;
        step();
        check_eq("abort_pop2_vec", obs, E_IDLE);
        check_eq("abort_pop2_sp", sp, 2);
        id = 3'b010;
        issue(c_NOP);
        check_eq("abort_after_vec", obs, E_IDLE);

        instr_en = 1'b1;
        issue(c_PUSH);
        check_eq("disable_push_vec", obs, E_DIS);
        check_eq("disable_push_sp", sp, 2);
        issue(c_POP);
        check_eq("disable_pop_vec", obs, E_DIS);
        instr_en = 1'b0;

        // Async reset while POP2 is on the outputs
        issue(c_POP);
        instr_in = c_NOP;
        step();
        check_eq("pre_async_vec", obs, E_POP2);
        check_eq("pre_async_sp", sp, 1);
        rst_n = 1'b0;
        #1;
        check_eq("async_vec", obs, E_IDLE);
        check_eq("async_sp", sp, 0);
        step();
        rst_n = 1'b1;
        step();
        check_eq("post_async_vec", obs, E_IDLE);

        // Deselect during RST_HOLD keeps sp cleared
        issue(c_PUSH);
        check_eq("pre_rsthold_sp", sp, 1);
        issue(c_RESET);
        check_eq("rsthold1_vec", obs, E_RESET);
        id = 3'b011;
        instr_in = c_NOP;
        step();
        check_eq("rsthold_abort_vec", obs, E_IDLE);
        check_eq("rsthold_abort_sp", sp, 0);
        id = 3'b010;
        step();
        check_eq("rsthold_after_vec", obs, E_IDLE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
